qif_spike_decoder: RTL and testbench
====================================

Name: qif_spike_decoder

Overview:
- Receive-side companion to the 8-bit QIF neuron. It samples the neuron's membrane bus V every cycle and detects spikes using hysteresis thresholds.
- Over a fixed cycle window it counts spikes and reports the count as a rate word. It also reports the most recent inter-spike interval (ISI).
- Sits between the neuron's V output and the readout/uio logic. Results are handed off through a valid/ready register.

Parameters:
- WINDOW, 16'd1000: window length in clock cycles, legal range 2..65535.
- V_PEAK, 8'd200: spike threshold. A spike is detected when v_in >= V_PEAK while the detector is armed.
- V_REARM, 8'd64: re-arm threshold. The detector re-arms when v_in < V_REARM. V_REARM < V_PEAK is required.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  decode enable. While low, the detector and counters freeze; the output register and handshake keep working.
- v_in  in  8  membrane potential from the neuron, unsigned, sampled every cycle.
- out_ready  in  1  consumer accepts the result.
- out_valid  out  1  result register holds an unconsumed result.
- rate  out  8  spike count of the last completed window, saturating at 255.
- isi  out  16  last inter-spike interval in cycles, saturating at 16'hFFFF.
- overrun  out  1  sticky flag: a window completed while out_valid=1 and out_ready=0.
- spike  out  1  one-cycle pulse on each detected spike, registered.

Behaviour:
- Reset (rst=1 at a clk edge): every output is 0, detector state is ARMED, window counter = 0, spike accumulator = 0, ISI counter = 0. Reset mid-window discards the partial window; no result is emitted.
- Detector FSM, evaluated only when ena=1:
  - ARMED -> FIRED when v_in >= V_PEAK. In that same edge, spike is asserted for exactly the next cycle.
  - FIRED -> ARMED when v_in < V_REARM.
  - Otherwise the state holds. Values between V_REARM and V_PEAK never cause a spike.
- Spike latency: v_in crossing at edge N gives spike=1 in cycle N+1.
- Window counter:
  - Increments each ena=1 cycle. At WINDOW-1 it wraps to 0 and the window closes.
  - At close, the result register loads rate = accumulator, with that cycle's spike included, saturating at 255.
  - In the same edge the accumulator resets to 0, or to 0 regardless of a spike on that cycle; that spike is counted in the closing window only.
- ISI counter:
  - Increments each ena=1 cycle, saturating at 16'hFFFF.
  - On a spike, isi_last <= counter+1 (saturating) and the counter resets to 0.
  - The first spike after reset reports cycles since reset.
  - isi is the isi_last value captured into the result register at window close.
- Handshake:
  - Window close sets out_valid=1.
  - out_valid falls at an edge where out_valid=1 and out_ready=1 and no window closes at that edge.
  - Close coinciding with acceptance: the new result loads, out_valid stays 1, overrun is unaffected.
  - Close while out_valid=1 and out_ready=0: the new result overwrites the old one, out_valid stays 1, overrun <= 1.
  - overrun clears only on rst.
  - rate and isi are stable whenever out_valid=1, except on the overwrite case.
- ena=0: the FSM, window, accumulator and ISI counters hold; spike=0. out_ready is still honoured.
- Arithmetic: all values unsigned. Counters use saturating compare, not wrap.

Optional Feature:
- Macro: QIF_DEC_ISI_EN.
- Defined: ISI counter and isi_last are implemented as described above.
- Undefined: ISI logic is not synthesised, the isi port is tied to 16'd0, and all other behaviour is unchanged.

Decomposition:
- Package qif_pkg holds:
  - localparam V_W = 8.
  - typedef enum {ARMED, FIRED} det_state_t.
  - RATE_MAX = 8'hFF and ISI_MAX = 16'hFFFF constants.
- Sub-module qif_spike_detect: the hysteresis FSM plus registered spike pulse. Inputs clk, rst, ena, v_in; output spike.
- The top level holds the window, accumulator, ISI and handshake logic.

Test Plan:
- Reset: rst high 2 cycles -> all outputs 0. v_in held at 255 afterwards -> exactly one spike pulse, at the cycle after the first sample.
- Hysteresis: v_in toggles 210/100/210 per cycle -> only the first 210 spikes (never re-armed). Then v_in=50, then 210 -> second spike.
- Rate: WINDOW=100, a periodic sawtooth giving a spike every 10 cycles, out_ready=1 -> out_valid pulses every 100 cycles with rate=10 and isi=10.
- Saturation: WINDOW=1000, a spike every 2 cycles -> rate=255. No spikes for 70000 cycles -> isi=16'hFFFF with QIF_DEC_ISI_EN defined, 0 without.
- Backpressure: out_ready=0 across two window closes -> out_valid stays 1, the second window's rate is visible, overrun=1. Then out_ready=1 for one cycle -> out_valid=0, overrun stays 1.
- ena/reset mid-window: ena=0 for 50 cycles mid-window -> close delayed by 50 cycles, counts unchanged. rst at cycle 40 of a window -> no out_valid until a full WINDOW after release.

Source files
------------

// File: rtl/qif_pkg.sv
// rtl/qif_pkg.sv - shared types, widths and saturating helpers for the QIF spike decoder
package qif_pkg;

  localparam int V_W = 8;

  typedef enum logic {ARMED, FIRED} det_state_t;

  localparam logic [7:0]  RATE_MAX = 8'hFF;
  localparam logic [15:0] ISI_MAX  = 16'hFFFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] x);
    return (x == RATE_MAX) ? RATE_MAX : x + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] x);
    return (x == ISI_MAX) ? ISI_MAX : x + 16'd1;
  endfunction

endpackage

// File: rtl/qif_spike_decoder_if.sv
// rtl/qif_spike_decoder_if.sv - valid/ready result bus carrying rate, isi and overrun
interface qif_spike_decoder_if;

  logic        out_valid;
  logic        out_ready;
  logic [7:0]  rate;
  logic [15:0] isi;
  logic        overrun;

  modport master (output out_valid, rate, isi, overrun, input out_ready);
  modport slave  (input out_valid, rate, isi, overrun, output out_ready);

endinterface

// File: rtl/qif_spike_detect.sv
// rtl/qif_spike_detect.sv - hysteresis spike detector with a registered one-cycle spike pulse
module qif_spike_detect
  import qif_pkg::*;
#(
  parameter logic [7:0] V_PEAK  = 8'd200,
  parameter logic [7:0] V_REARM = 8'd64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic [V_W-1:0] v_in,
  output logic           spike
);

  det_state_t state;
  det_state_t state_next;
  logic       spike_next;

  // State and pulse registers; the pulse is 1 only in the cycle after a firing edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARMED;
      spike <= 1'b0;
    end else begin
      state <= state_next;
      spike <= spike_next;
    end
  end

  // Fire on reaching the peak while armed; re-arm only below the lower threshold
  always_comb begin
    state_next = state;
    spike_next = 1'b0;
    if (ena) begin
      case (state)
        ARMED: begin
          if (v_in >= V_PEAK) begin
            state_next = FIRED;
            spike_next = 1'b1;
          end
        end
        FIRED: begin
          if (v_in < V_REARM) begin
            state_next = ARMED;
          end
        end
        default: state_next = ARMED;
      endcase
    end
  end

endmodule

// File: rtl/qif_spike_decoder.sv
// rtl/qif_spike_decoder.sv - spike rate / ISI decoder top; QIF_DEC_ISI_EN enables the ISI path
module qif_spike_decoder
  import qif_pkg::*;
#(
  parameter logic [15:0] WINDOW  = 16'd1000,
  parameter logic [7:0]  V_PEAK  = 8'd200,
  parameter logic [7:0]  V_REARM = 8'd64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic [V_W-1:0]             v_in,
  output logic                       spike,
  qif_spike_decoder_if.master        res
);

  logic [15:0] win_cnt;
  logic [7:0]  acc;
  logic        win_close;
  logic [7:0]  rate_close;
  logic [15:0] isi_last_next;

  logic        valid_q;
  logic        overrun_q;
  logic [7:0]  rate_q;
  logic [15:0] isi_q;

  qif_spike_detect #(
    .V_PEAK  (V_PEAK),
    .V_REARM (V_REARM)
  ) u_detect (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .v_in  (v_in),
    .spike (spike)
  );

  // The closing cycle's own spike belongs to the window that is closing
  assign win_close  = ena && (win_cnt == WINDOW - 16'd1);
  assign rate_close = spike ? sat_inc8(acc) : acc;

  // Window counter advances on enabled cycles; the spike count is cleared at close.
  // A pulse can land in the first cycle after ena drops, so it is counted regardless of ena.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt <= 16'd0;
      acc     <= 8'd0;
    end else begin
      if (ena) begin
        win_cnt <= win_close ? 16'd0 : win_cnt + 16'd1;
      end
      acc <= win_close ? 8'd0 : rate_close;
    end
  end

`ifdef QIF_DEC_ISI_EN
  logic [15:0] isi_cnt;
  logic [15:0] isi_last;

  assign isi_last_next = spike ? sat_inc16(isi_cnt) : isi_last;

  // Cycles since the previous spike (or reset); the pulse cycle itself closes the interval
  always_ff @(posedge clk) begin
    if (rst) begin
      isi_cnt  <= 16'd0;
      isi_last <= 16'd0;
    end else begin
      isi_last <= isi_last_next;
      if (spike) begin
        isi_cnt <= 16'd0;
      end else if (ena) begin
        isi_cnt <= sat_inc16(isi_cnt);
      end
    end
  end
`else
  assign isi_last_next = 16'd0;
`endif

  // Result register: load on close, drop valid on acceptance, flag a dropped result as overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      rate_q    <= 8'd0;
      isi_q     <= 16'd0;
    end else if (win_close) begin
      rate_q  <= rate_close;
      isi_q   <= isi_last_next;
      valid_q <= 1'b1;
      if (valid_q && !res.out_ready) begin
        overrun_q <= 1'b1;
      end
    end else if (valid_q && res.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign res.out_valid = valid_q;
  assign res.overrun   = overrun_q;
  assign res.rate      = rate_q;
  assign res.isi       = isi_q;

endmodule

// File: tb/tb_qif_spike_decoder.sv
// tb/tb_qif_spike_decoder.sv - self-checking bench for qif_spike_decoder (WINDOW 100 and 1000)
module tb_qif_spike_decoder;

`ifdef QIF_DEC_ISI_EN
  localparam bit ISI_EN = 1'b1;
`else
  localparam bit ISI_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] v;
  logic       rdy;
  logic       spike_a;
  logic       spike_b;

  always #5 clk = ~clk;

  qif_spike_decoder_if res_a ();
  qif_spike_decoder_if res_b ();

  assign res_a.out_ready = rdy;
  assign res_b.out_ready = rdy;

  qif_spike_decoder #(.WINDOW(16'd100)) dut_a (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .v_in  (v),
    .spike (spike_a),
    .res   (res_a)
  );

  qif_spike_decoder #(.WINDOW(16'd1000)) dut_b (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .v_in  (v),
    .spike (spike_b),
    .res   (res_b)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: event-time view (enabled-cycle timestamps, unbounded counts, clipped on report)
  bit     m_armed;
  bit     m_spike;
  longint e_total;
  longint e_mark;
  longint isi_last;
  longint acc [2];
  bit     m_valid [2];
  bit     m_over [2];
  longint m_rate [2];
  longint m_isi [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit     new_spike;
    bit     close;
    longint wl;
    if (rst) begin
      m_armed = 1; m_spike = 0; e_total = 0; e_mark = 0; isi_last = 0;
      for (int k = 0; k < 2; k++) begin
        acc[k] = 0; m_valid[k] = 0; m_over[k] = 0; m_rate[k] = 0; m_isi[k] = 0;
      end
    end else begin
      new_spike = 0;
      if (ena) begin
        if (m_armed && v >= 8'd200) begin
          new_spike = 1;
          m_armed = 0;
        end else if (!m_armed && v < 8'd64) begin
          m_armed = 1;
        end
      end
      if (m_spike) isi_last = e_total - e_mark + 1;
      for (int k = 0; k < 2; k++) begin
        wl = (k == 0) ? 100 : 1000;
        close = ena && (((e_total + 1) % wl) == 0);
        if (close) begin
          m_rate[k] = (acc[k] + m_spike > 255) ? 255 : acc[k] + m_spike;
          m_isi[k]  = ISI_EN ? ((isi_last > 65535) ? 65535 : isi_last) : 0;
          if (m_valid[k] && !rdy) m_over[k] = 1;
          m_valid[k] = 1;
          acc[k] = 0;
        end else begin
          acc[k] += m_spike;
          if (m_valid[k] && rdy) m_valid[k] = 0;
        end
      end
      if (ena) e_total++;
      if (m_spike) e_mark = e_total;
      m_spike = new_spike;
    end
  endtask

  task automatic step(input bit r, input bit e, input logic [7:0] vv, input bit rd);
    rst = r; ena = e; v = vv; rdy = rd;
    model_update();
    @(posedge clk);
    #1;
    check("a_spike",   {31'd0, spike_a},         {31'd0, m_spike});
    check("a_valid",   {31'd0, res_a.out_valid}, {31'd0, m_valid[0]});
    check("a_overrun", {31'd0, res_a.overrun},   {31'd0, m_over[0]});
    check("a_rate",    {24'd0, res_a.rate},      m_rate[0][31:0]);
    check("a_isi",     {16'd0, res_a.isi},       m_isi[0][31:0]);
    check("b_spike",   {31'd0, spike_b},         {31'd0, m_spike});
    check("b_valid",   {31'd0, res_b.out_valid}, {31'd0, m_valid[1]});
    check("b_overrun", {31'd0, res_b.overrun},   {31'd0, m_over[1]});
    check("b_rate",    {24'd0, res_b.rate},      m_rate[1][31:0]);
    check("b_isi",     {16'd0, res_b.isi},       m_isi[1][31:0]);
  endtask

  typedef struct {
    bit         rst;
    bit         ena;
    logic [7:0] v;
    bit         spike;
  } vec_t;

  vec_t tbl [22];
  int   nvalid;
  int   found_at;
  bit   found;
  bit   r_rst;
  bit   r_ena;
  bit   r_rdy;

  initial begin
    rst = 1; ena = 1; v = 0; rdy = 1;

    // Reset, hold-at-255, hysteresis band, exact thresholds, ena freeze
    tbl[0]  = '{1, 1, 8'd0,   0};
    tbl[1]  = '{1, 1, 8'd0,   0};
    tbl[2]  = '{0, 1, 8'd255, 1};
    tbl[3]  = '{0, 1, 8'd255, 0};
    tbl[4]  = '{0, 1, 8'd255, 0};
    tbl[5]  = '{0, 1, 8'd210, 0};
    tbl[6]  = '{0, 1, 8'd100, 0};
    tbl[7]  = '{0, 1, 8'd210, 0};
    tbl[8]  = '{0, 1, 8'd100, 0};
    tbl[9]  = '{0, 1, 8'd50,  0};
    tbl[10] = '{0, 1, 8'd210, 1};
    tbl[11] = '{0, 1, 8'd63,  0};
    tbl[12] = '{0, 1, 8'd199, 0};
    tbl[13] = '{0, 1, 8'd200, 1};
    tbl[14] = '{0, 1, 8'd64,  0};
    tbl[15] = '{0, 1, 8'd255, 0};
    tbl[16] = '{0, 0, 8'd10,  0};
    tbl[17] = '{0, 0, 8'd255, 0};
    tbl[18] = '{0, 1, 8'd255, 0};
    tbl[19] = '{0, 1, 8'd10,  0};
    tbl[20] = '{0, 0, 8'd255, 0};
    tbl[21] = '{0, 1, 8'd255, 1};

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].rst, tbl[i].ena, tbl[i].v, 1'b1);
      check("tbl_spike", {31'd0, spike_a}, {31'd0, tbl[i].spike});
      if (i == 1) begin
        check("rst_valid",   {31'd0, res_a.out_valid}, 32'd0);
        check("rst_overrun", {31'd0, res_a.overrun},   32'd0);
        check("rst_rate",    {24'd0, res_a.rate},      32'd0);
        check("rst_isi",     {16'd0, res_a.isi},       32'd0);
      end
    end

    // Periodic sawtooth, one spike per 10 cycles, WINDOW=100
    step(1, 1, 0, 1); step(1, 1, 0, 1);
    nvalid = 0;
    for (int k = 0; k < 300; k++) begin
      step(0, 1, 8'((k % 10) * 25), 1);
      if (res_a.out_valid) begin
        nvalid++;
        check("saw_rate", {24'd0, res_a.rate}, 32'd10);
        check("saw_isi",  {16'd0, res_a.isi},  ISI_EN ? 32'd10 : 32'd0);
      end
    end
    check("saw_nvalid", nvalid, 32'd3);

    // Rate saturation, spike every 2 cycles, WINDOW=1000
    step(1, 1, 0, 1); step(1, 1, 0, 1);
    for (int k = 0; k < 1000; k++) step(0, 1, (k % 2) ? 8'd0 : 8'd255, 1);
    check("sat_valid", {31'd0, res_b.out_valid}, 32'd1);
    check("sat_rate",  {24'd0, res_b.rate},      32'd255);

    // ISI saturation: 70000 quiet cycles between two spikes
    step(1, 1, 0, 1); step(1, 1, 0, 1);
    step(0, 1, 255, 1);
    for (int k = 0; k < 70000; k++) step(0, 1, 0, 1);
    step(0, 1, 255, 1);
    found = 0;
    for (int k = 0; k < 150 && !found; k++) begin
      step(0, 1, 0, 1);
      if (res_a.out_valid) begin
        found = 1;
        check("isi_sat", {16'd0, res_a.isi}, ISI_EN ? 32'hFFFF : 32'd0);
      end
    end
    check("isi_sat_seen", {31'd0, found}, 32'd1);

    // Backpressure across two closes, then a single accept
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    for (int k = 0; k < 100; k++) step(0, 1, 8'((k % 10) * 25), 0);
    check("bp1_valid",   {31'd0, res_a.out_valid}, 32'd1);
    check("bp1_overrun", {31'd0, res_a.overrun},   32'd0);
    check("bp1_rate",    {24'd0, res_a.rate},      32'd10);
    for (int k = 100; k < 200; k++) step(0, 1, (k % 2) ? 8'd0 : 8'd255, 0);
    check("bp2_valid",   {31'd0, res_a.out_valid}, 32'd1);
    check("bp2_overrun", {31'd0, res_a.overrun},   32'd1);
    check("bp2_rate",    {24'd0, res_a.rate},      32'd49);
    step(0, 1, 0, 1);
    check("bp3_valid",   {31'd0, res_a.out_valid}, 32'd0);
    check("bp3_overrun", {31'd0, res_a.overrun},   32'd1);

    // ena low for 50 cycles mid-window delays the close by 50
    step(1, 1, 0, 1); step(1, 1, 0, 1);
    found_at = 0;
    for (int s = 1; s <= 300 && found_at == 0; s++) begin
      step(0, !(s > 30 && s <= 80), 0, 1);
      if (res_a.out_valid) found_at = s;
    end
    check("ena_close_at", found_at, 32'd150);

    // Reset 40 cycles into a window restarts it
    step(1, 1, 0, 1); step(1, 1, 0, 1);
    for (int s = 0; s < 40; s++) step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    found_at = 0;
    for (int s = 1; s <= 300 && found_at == 0; s++) begin
      step(0, 1, 0, 1);
      if (res_a.out_valid) found_at = s;
    end
    check("rst_close_at", found_at, 32'd100);

    // Randomized traffic against the model
    step(1, 1, 0, 1);
    for (int k = 0; k < 4000; k++) begin
      r_rst = ($urandom_range(0, 599) == 0);
      r_ena = ($urandom_range(0, 9) != 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0:       step(r_rst, r_ena, 8'($urandom_range(0, 70)), r_rdy);
        1:       step(r_rst, r_ena, 8'($urandom_range(190, 255)), r_rdy);
        default: step(r_rst, r_ena, 8'($urandom_range(0, 255)), r_rdy);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
